// File: rtl/signature_serializer.sv
// Signature serializer: streams a constant signature word out OUT_W bits per
// beat under an advance enable, with selectable bit order and one-shot or
// looping playback. Drives the signature/ID readout pins.
module signature_serializer #(
  parameter int unsigned         SIG_BITS   = 256,
  parameter logic [SIG_BITS-1:0] SIG_VALUE  = "Luke Vassallo Tiny Tapeout 2023.",
  parameter int unsigned         OUT_W      = 1,
  parameter bit                  AUTO_START = 1'b1,
  parameter int unsigned         IDX_W      = $clog2(SIG_BITS / OUT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic             en,
  input  logic             loop,
  input  logic             lsb_first,
  output logic [OUT_W-1:0] q,
  output logic             q_valid,
  output logic             done,
  output logic             wrap,
  output logic [IDX_W-1:0] beat_idx
);

  localparam int unsigned    N     = SIG_BITS / OUT_W;
  localparam int unsigned    SH_W  = $clog2(SIG_BITS) + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  // Reject geometries that cannot be split into at least two whole beats.
  if ((SIG_BITS % OUT_W) != 0 || N < 2 ||
      !(OUT_W == 1 || OUT_W == 2 || OUT_W == 4 || OUT_W == 8 ||
        OUT_W == 16 || OUT_W == 32)) begin : g_param_err
    $error("signature_serializer: illegal SIG_BITS/OUT_W combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam state_t RESET_STATE = AUTO_START ? RUN : IDLE;

  state_t           state;
  state_t           state_d;
  logic [IDX_W-1:0] beat_d;
  logic             loop_r;
  logic             loop_d;
  logic             lsb_r;
  logic             lsb_d;
  logic             wrap_d;

  logic [SH_W-1:0]     shamt;
  logic [SIG_BITS-1:0] msb_word;
  logic [SIG_BITS-1:0] lsb_word;

  // State and playback registers; reset may strike at any time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RESET_STATE;
      beat_idx <= '0;
      loop_r   <= 1'b0;
      lsb_r    <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_d;
      beat_idx <= beat_d;
      loop_r   <= loop_d;
      lsb_r    <= lsb_d;
      wrap     <= wrap_d;
    end
  end

  // Next-state logic: ld restarts and wins over en; en advances only in RUN.
  always_comb begin
    state_d = state;
    beat_d  = beat_idx;
    loop_d  = loop_r;
    lsb_d   = lsb_r;
    wrap_d  = 1'b0;
    if (ld) begin
      state_d = RUN;
      beat_d  = '0;
      loop_d  = loop;
      lsb_d   = lsb_first;
    end else if (en && state == RUN) begin
      if (beat_idx == LAST) begin
        if (loop_r) begin
          beat_d = '0;
          wrap_d = 1'b1;
        end else begin
          state_d = DONE;
        end
      end else begin
        beat_d = beat_idx + IDX_W'(1);
      end
    end
  end

  // Beat selection: shift the signature so the current beat lands at an end.
  always_comb begin
    shamt    = SH_W'(beat_idx) * SH_W'(OUT_W);
    msb_word = SIG_VALUE << shamt;
    lsb_word = SIG_VALUE >> shamt;
    q        = '0;
    if (state == RUN) begin
      q = lsb_r ? lsb_word[OUT_W-1:0] : msb_word[SIG_BITS-1 -: OUT_W];
    end
  end

  // Status flags follow the state register directly.
  assign q_valid = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_signature_serializer.sv
// Directed bench for signature_serializer: a bit-serial auto-start instance
// and a byte-wide instance that waits for ld.
module tb_signature_serializer;

  localparam logic [255:0] SIG = "Luke Vassallo Tiny Tapeout 2023.";

  logic       clk;
  logic       rst1, ld1, en1, loop1, lsb1;
  logic       rst8, ld8, en8, loop8, lsb8;
  logic [0:0] q1;
  logic [7:0] q8;
  logic       q_valid1, done1, wrap1;
  logic       q_valid8, done8, wrap8;
  logic [7:0] beat_idx1;
  logic [4:0] beat_idx8;

  int checks;
  int failures;

  signature_serializer u_dut1 (
    .clk       (clk),
    .reset     (rst1),
    .ld        (ld1),
    .en        (en1),
    .loop      (loop1),
    .lsb_first (lsb1),
    .q         (q1),
    .q_valid   (q_valid1),
    .done      (done1),
    .wrap      (wrap1),
    .beat_idx  (beat_idx1)
  );

  signature_serializer #(
    .OUT_W      (8),
    .AUTO_START (1'b0)
  ) u_dut8 (
    .clk       (clk),
    .reset     (rst8),
    .ld        (ld8),
    .en        (en8),
    .loop      (loop8),
    .lsb_first (lsb8),
    .q         (q8),
    .q_valid   (q_valid8),
    .done      (done8),
    .wrap      (wrap8),
    .beat_idx  (beat_idx8)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sig_byte(input int k);
    logic [255:0] s;
    s = SIG;
    return s[255-8*k -: 8];
  endfunction

  function automatic logic sig_bit(input int i);
    logic [255:0] s;
    s = SIG;
    return s[255-i];
  endfunction

  function automatic logic [7:0] hand_byte(input int k);
    case (k)
      0:       return 8'h4C;
      1:       return 8'h75;
      2:       return 8'h6B;
      3:       return 8'h65;
      default: return 8'h2E;
    endcase
  endfunction

  initial begin
    logic [7:0] first8;
    checks   = 0;
    failures = 0;
    clk  = 1'b0;
    rst1 = 1'b1; ld1 = 1'b0; en1 = 1'b0; loop1 = 1'b0; lsb1 = 1'b0;
    rst8 = 1'b1; ld8 = 1'b0; en8 = 1'b0; loop8 = 1'b0; lsb8 = 1'b0;
    first8 = 8'b0100_1100;
    tick;
    tick;

    chk("rst_valid1", 32'(q_valid1), 32'd1);
    chk("rst_idx1",   32'(beat_idx1), 32'd0);
    chk("rst_q1",     32'(q1), 32'd0);
    chk("rst_wrap1",  32'(wrap1), 32'd0);
    chk("rst_done1",  32'(done1), 32'd0);
    chk("rst_valid8", 32'(q_valid8), 32'd0);
    chk("rst_q8",     32'(q8), 32'd0);

    rst1 = 1'b0; rst8 = 1'b0;
    en1 = 1'b1; en8 = 1'b1;
    #1;
    chk("run_valid1", 32'(q_valid1), 32'd1);

    // Bit-serial MSB-first stream of the whole signature.
    for (int i = 0; i < 256; i++) begin
      if (i < 8) chk($sformatf("first8_bit%0d", i), 32'(q1), 32'(first8[7-i]));
      chk($sformatf("msb_bit%0d", i), 32'(q1), 32'(sig_bit(i)));
      chk($sformatf("msb_idx%0d", i), 32'(beat_idx1), 32'(i));
      tick;
    end
    chk("end_done1",  32'(done1), 32'd1);
    chk("end_valid1", 32'(q_valid1), 32'd0);
    chk("end_q1",     32'(q1), 32'd0);
    chk("end_idx1",   32'(beat_idx1), 32'd255);
    tick; tick; tick;
    chk("done_hold1", 32'(done1), 32'd1);
    chk("done_idx1",  32'(beat_idx1), 32'd255);

    // Idle instance ignored en throughout.
    chk("idle_valid8", 32'(q_valid8), 32'd0);
    chk("idle_idx8",   32'(beat_idx8), 32'd0);
    chk("idle_done8",  32'(done8), 32'd0);
    chk("idle_q8",     32'(q8), 32'd0);

    // ld with en: restart at beat 0, en ignored.
    ld1 = 1'b1; en1 = 1'b1;
    tick;
    ld1 = 1'b0;
    chk("ld_idx1",   32'(beat_idx1), 32'd0);
    chk("ld_valid1", 32'(q_valid1), 32'd1);
    for (int i = 0; i < 10; i++) tick;
    chk("mid_idx1", 32'(beat_idx1), 32'd10);
    chk("mid_q1",   32'(q1), 32'(sig_bit(10)));
    ld1 = 1'b1;
    tick;
    ld1 = 1'b0;
    chk("ld_en_idx1", 32'(beat_idx1), 32'd0);
    for (int i = 0; i < 5; i++) tick;
    chk("adv_idx1", 32'(beat_idx1), 32'd5);
    en1 = 1'b0;
    tick; tick;
    chk("hold_idx1", 32'(beat_idx1), 32'd5);

    // Asynchronous reset between clock edges.
    #2 rst1 = 1'b1;
    #1;
    chk("async_idx1",   32'(beat_idx1), 32'd0);
    chk("async_valid1", 32'(q_valid1), 32'd1);
    chk("async_q1",     32'(q1), 32'(sig_bit(0)));
    tick;
    rst1 = 1'b0;

    // Byte-wide MSB-first one-shot after ld.
    en8 = 1'b0; ld8 = 1'b1; lsb8 = 1'b0; loop8 = 1'b0;
    tick;
    ld8 = 1'b0;
    chk("ld_valid8", 32'(q_valid8), 32'd1);
    en8 = 1'b1;
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("msb8_q%0d", k), 32'(q8), 32'(sig_byte(k)));
      chk($sformatf("msb8_idx%0d", k), 32'(beat_idx8), 32'(k));
      if (k < 4 || k == 31) chk($sformatf("msb8_hand%0d", k), 32'(q8), 32'(hand_byte(k)));
      tick;
    end
    chk("msb8_done",  32'(done8), 32'd1);
    chk("msb8_q_end", 32'(q8), 32'd0);
    chk("msb8_idx_end", 32'(beat_idx8), 32'd31);

    // Byte-wide LSB-first; mode inputs toggled mid-stream must not matter.
    ld8 = 1'b1; lsb8 = 1'b1; loop8 = 1'b0;
    tick;
    ld8 = 1'b0; lsb8 = 1'b0; loop8 = 1'b1;
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("lsb8_q%0d", k), 32'(q8), 32'(sig_byte(31 - k)));
      if (k == 0)  chk("lsb8_hand0",  32'(q8), 32'h2E);
      if (k == 1)  chk("lsb8_hand1",  32'(q8), 32'h33);
      if (k == 31) chk("lsb8_hand31", 32'(q8), 32'h4C);
      tick;
    end
    chk("lsb8_done", 32'(done8), 32'd1);
    chk("lsb8_wrap", 32'(wrap8), 32'd0);

    // Looping playback: one wrap pulse, never done.
    ld8 = 1'b1; loop8 = 1'b1; lsb8 = 1'b0;
    tick;
    ld8 = 1'b0; loop8 = 1'b0;
    for (int k = 0; k < 31; k++) begin
      chk($sformatf("loop_wrap%0d", k), 32'(wrap8), 32'd0);
      tick;
    end
    chk("loop_idx31", 32'(beat_idx8), 32'd31);
    chk("loop_q31",   32'(q8), 32'h2E);
    tick;
    chk("wrap_pulse",  32'(wrap8), 32'd1);
    chk("wrap_idx",    32'(beat_idx8), 32'd0);
    chk("wrap_q",      32'(q8), 32'h4C);
    chk("wrap_done",   32'(done8), 32'd0);
    chk("wrap_valid",  32'(q_valid8), 32'd1);
    en8 = 1'b0;
    tick;
    chk("wrap_clear",  32'(wrap8), 32'd0);
    chk("wrap_hold",   32'(beat_idx8), 32'd0);
    en8 = 1'b1;
    tick;
    chk("wrap_adv",    32'(beat_idx8), 32'd1);
    chk("wrap_low",    32'(wrap8), 32'd0);
    chk("wrap_q1",     32'(q8), 32'h75);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
